// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve signal bundle for the branch predictor.
// Latency: none of its own; it only carries wires.
// Backpressure: none. Lookups and resolves are accepted every cycle.
interface branch_predictor_if #(
    parameter int DATA_LEN = 32
);
    // IF-stage lookup
    logic [DATA_LEN-1:0] if_pc;
    logic                pred_taken;
    logic [DATA_LEN-1:0] pred_target;

    // EX-stage resolve
    logic                upd_valid;
    logic [DATA_LEN-1:0] upd_pc;
    logic                upd_is_jal;
    logic                upd_taken;
    logic [DATA_LEN-1:0] upd_target;
    logic                upd_pred_taken;
    logic [DATA_LEN-1:0] upd_pred_target;
    logic                mispredict;
    logic [DATA_LEN-1:0] redirect_pc;

    // Pipeline side: drives PCs and resolved outcomes, consumes predictions.
    modport master (
        output if_pc, upd_valid, upd_pc, upd_is_jal, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    // Predictor side.
    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_is_jal, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters; optional stats via BP_STATS_EN.
// Latency: lookup and mispredict/redirect are combinational; table writes land on the next clk edge.
// Backpressure: none. One lookup and one resolve are accepted every cycle.
module branch_predictor #(
    parameter int DATA_LEN = 32,
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    branch_predictor_if.slave   bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = DATA_LEN - IDX - 2;

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_WT  = {1'b1, {(CNT_BITS-1){1'b0}}};
    localparam logic [CNT_BITS-1:0] CNT_WNT = {1'b0, {(CNT_BITS-1){1'b1}}};

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q [ENTRIES];
    logic [DATA_LEN-1:0] tgt_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q [ENTRIES];

    logic [IDX-1:0]      look_idx;
    logic [TAG_W-1:0]    look_tag;
    logic                look_hit;

    logic [IDX-1:0]      upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;
    logic [CNT_BITS-1:0] cnt_cur;
    logic [CNT_BITS-1:0] cnt_d;
    logic                wr_en;

    // Fetch-side lookup: reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        look_idx       = bp.if_pc[IDX+1:2];
        look_tag       = bp.if_pc[DATA_LEN-1:IDX+2];
        look_hit       = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
        bp.pred_taken  = look_hit && cnt_q[look_idx][CNT_BITS-1];
        bp.pred_target = bp.pred_taken ? tgt_q[look_idx] : bp.if_pc + DATA_LEN'(4);
    end

    // Resolve-side next counter value; a miss that is taken allocates, a miss not taken leaves the table alone.
    always_comb begin
        upd_idx = bp.upd_pc[IDX+1:2];
        upd_tag = bp.upd_pc[DATA_LEN-1:IDX+2];
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        cnt_cur = cnt_q[upd_idx];
        cnt_d   = cnt_cur;
        if (upd_hit) begin
            if (bp.upd_is_jal)
                cnt_d = CNT_MAX;
            else if (bp.upd_taken)
                cnt_d = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_BITS'(1);
            else
                cnt_d = (cnt_cur == CNT_ZERO) ? cnt_cur : cnt_cur - CNT_BITS'(1);
        end else begin
            cnt_d = bp.upd_is_jal ? CNT_MAX : CNT_WT;
        end
        wr_en = bp.upd_valid && (upd_hit || bp.upd_taken);
    end

    // The pipeline compares what it was told against the real outcome; redirect is always driven.
    assign bp.mispredict  = bp.upd_valid &&
                            ((bp.upd_taken != bp.upd_pred_taken) ||
                             (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
    assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + DATA_LEN'(4);

    // Table state: async clear to invalid/weakly-not-taken, single-entry write per resolve.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= CNT_WNT;
            end
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            cnt_q[upd_idx]   <= cnt_d;
            if (bp.upd_taken)
                tgt_q[upd_idx] <= bp.upd_target;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (bp.upd_valid)
                stat_br_q <= stat_br_q + 32'd1;
            if (bp.mispredict)
                stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations queued with stimulus, drained against outputs.
// Latency: checks combinational outputs 1ns after driving; table effects checked after the next edge.
// Backpressure: none.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_if #(.DATA_LEN(32)) bp();

`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.DATA_LEN(32), .ENTRIES(16), .CNT_BITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    localparam int K_PT = 0, K_TGT = 1, K_MP = 2, K_RD = 3, K_SB = 4, K_SM = 5;

    int          checks = 0;
    int          errors = 0;
    int          exp_kind [$];
    logic [31:0] exp_val  [$];
    string       exp_name [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int k);
        case (k)
            K_PT:    return {31'b0, bp.pred_taken};
            K_TGT:   return bp.pred_target;
            K_MP:    return {31'b0, bp.mispredict};
            K_RD:    return bp.redirect_pc;
`ifdef BP_STATS_EN
            K_SB:    return stat_branches;
            K_SM:    return stat_mispredicts;
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic sb_push(input string name, input int k, input logic [31:0] v);
        exp_name.push_back(name);
        exp_kind.push_back(k);
        exp_val.push_back(v);
    endtask

    task automatic sb_drain();
        #1;
        while (exp_kind.size() > 0) begin
            string       n;
            int          k;
            logic [31:0] v;
            n = exp_name.pop_front();
            k = exp_kind.pop_front();
            v = exp_val.pop_front();
            check(n, observe(k), v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bp.upd_valid = 1'b0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic jal, input logic tk,
                             input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bp.upd_valid       = 1'b1;
        bp.upd_pc          = pc;
        bp.upd_is_jal      = jal;
        bp.upd_taken       = tk;
        bp.upd_target      = tgt;
        bp.upd_pred_taken  = ptk;
        bp.upd_pred_target = ptgt;
    endtask

    task automatic lookup_check(input string name, input logic [31:0] pc,
                                input logic pt, input logic [31:0] tgt);
        bp.if_pc = pc;
        sb_push({name, "_pt"}, K_PT, {31'b0, pt});
        sb_push({name, "_tgt"}, K_TGT, tgt);
        sb_drain();
    endtask

    // One resolve: check same-cycle mispredict/redirect, then let it commit.
    task automatic do_upd(input string name, input logic [31:0] pc, input logic jal, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                          input logic mp, input logic [31:0] rd);
        drive_upd(pc, jal, tk, tgt, ptk, ptgt);
        sb_push({name, "_mp"}, K_MP, {31'b0, mp});
        sb_push({name, "_rd"}, K_RD, rd);
        sb_drain();
        cyc();
        idle();
    endtask

    initial begin
        reset = 1'b0;
        bp.if_pc = 32'h100;
        drive_upd(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();

        // Reset state, while held and after release.
        #2;
        lookup_check("rst_hold", 32'h100, 1'b0, 32'h104);
        sb_push("rst_mp", K_MP, 32'd0);
        sb_drain();
        cyc();
        reset = 1'b1;
        lookup_check("rst_rel", 32'h100, 1'b0, 32'h104);

        // Allocation, with a same-cycle lookup seeing the old contents.
        bp.if_pc = 32'h100;
        drive_upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        sb_push("alloc_old_pt", K_PT, 32'd0);
        sb_push("alloc_mp", K_MP, 32'd1);
        sb_push("alloc_rd", K_RD, 32'h80);
        sb_drain();
        cyc();
        idle();
        lookup_check("alloc_hit", 32'h100, 1'b1, 32'h80);

        // Hysteresis and saturation at both ends (entry starts at weakly taken).
        do_upd("h1", 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80,  1'b1, 32'h104);
        lookup_check("h1_look", 32'h100, 1'b0, 32'h104);
        do_upd("h2", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
        do_upd("h3", 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80,  1'b0, 32'h80);
        lookup_check("h3_look", 32'h100, 1'b1, 32'h80);
        do_upd("h4", 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80,  1'b1, 32'h104);
        lookup_check("h4_look", 32'h100, 1'b1, 32'h80);
        do_upd("h5", 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80,  1'b0, 32'h80);
        do_upd("h6", 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80,  1'b0, 32'h80);
        do_upd("h7", 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80,  1'b1, 32'h104);
        lookup_check("h7_look", 32'h100, 1'b1, 32'h80);
        do_upd("h8", 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80,  1'b1, 32'h104);
        lookup_check("h8_look", 32'h100, 1'b0, 32'h104);
        do_upd("h9",  32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104);
        do_upd("h10", 32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104);
        do_upd("h11", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
        lookup_check("h11_look", 32'h100, 1'b0, 32'h104);
        do_upd("h12", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
        lookup_check("h12_look", 32'h100, 1'b1, 32'h80);

        // JAL allocation (0x200 shares index 0 with 0x100) and target change.
        do_upd("jal1", 32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204, 1'b1, 32'h400);
        lookup_check("jal1_look", 32'h200, 1'b1, 32'h400);
        lookup_check("jal1_evict", 32'h100, 1'b0, 32'h104);
        do_upd("jal2", 32'h200, 1'b1, 1'b1, 32'h500, 1'b1, 32'h400, 1'b1, 32'h500);
        lookup_check("jal2_look", 32'h200, 1'b1, 32'h500);
        do_upd("jal3", 32'h200, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0, 32'h500);

        // upd_valid=0: no mispredict and no table write.
        drive_upd(32'h200, 1'b0, 1'b1, 32'h777, 1'b0, 32'h1234);
        idle();
        sb_push("novld_mp", K_MP, 32'd0);
        sb_drain();
        cyc();
        lookup_check("novld_look", 32'h200, 1'b1, 32'h500);

        // Aliasing on index 0.
        do_upd("al1", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
        lookup_check("al1_look", 32'h100, 1'b1, 32'h80);
        lookup_check("al1_evict", 32'h200, 1'b0, 32'h204);
        do_upd("al2", 32'h140, 1'b0, 1'b1, 32'h900, 1'b0, 32'h144, 1'b1, 32'h900);
        lookup_check("al2_evict", 32'h100, 1'b0, 32'h104);
        lookup_check("al2_look", 32'h140, 1'b1, 32'h900);

        // Same-cycle lookup and update of index 0: lookup sees old contents.
        bp.if_pc = 32'h140;
        drive_upd(32'h140, 1'b0, 1'b0, 32'h900, 1'b1, 32'h900);
        sb_push("sc_pt", K_PT, 32'd1);
        sb_push("sc_tgt", K_TGT, 32'h900);
        sb_push("sc_mp", K_MP, 32'd1);
        sb_push("sc_rd", K_RD, 32'h144);
        sb_drain();
        cyc();
        idle();
        lookup_check("sc_after", 32'h140, 1'b0, 32'h144);

        // Miss not taken does not allocate.
        do_upd("mnt", 32'h1004, 1'b0, 1'b0, 32'h2000, 1'b0, 32'h1008, 1'b0, 32'h1008);
        lookup_check("mnt_look", 32'h1004, 1'b0, 32'h1008);

        // Address wrap.
        lookup_check("wrap_look", 32'hFFFF_FFFC, 1'b0, 32'h0);
        do_upd("wrap_upd", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Asynchronous reset clears the table without a clock edge.
        do_upd("ar_alloc", 32'h1004, 1'b0, 1'b1, 32'h3000, 1'b0, 32'h1008, 1'b1, 32'h3000);
        lookup_check("ar_before", 32'h1004, 1'b1, 32'h3000);
        reset = 1'b0;
        lookup_check("ar_now", 32'h1004, 1'b0, 32'h1008);
        // An update presented across an edge under reset is discarded.
        drive_upd(32'h1004, 1'b0, 1'b1, 32'h3000, 1'b0, 32'h1008);
        cyc();
        idle();
        reset = 1'b1;
        lookup_check("ar_discard", 32'h1004, 1'b0, 32'h1008);
        do_upd("ar_first", 32'h1004, 1'b0, 1'b1, 32'h3000, 1'b0, 32'h1008, 1'b1, 32'h3000);
        lookup_check("ar_first_look", 32'h1004, 1'b1, 32'h3000);

`ifdef BP_STATS_EN
        // Statistics: 10 resolves, first 3 mispredicted, then async clear.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        sb_push("st_clr_br", K_SB, 32'd0);
        sb_push("st_clr_mp", K_SM, 32'd0);
        sb_drain();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] pc;
            pc = 32'h2000 + 32'(4 * i);
            do_upd("st_upd", pc, 1'b0, 1'b0, 32'h0, (i < 3), 32'h0, (i < 3), pc + 32'd4);
        end
        sb_push("st_br", K_SB, 32'd10);
        sb_push("st_mp", K_SM, 32'd3);
        sb_drain();
        reset = 1'b0;
        sb_push("st_rst_br", K_SB, 32'd0);
        sb_push("st_rst_mp", K_SM, 32'd0);
        sb_drain();
        reset = 1'b1;
`endif

        // Random resolves: mispredict and redirect are a pure function of the inputs.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] pc, tgt, ptgt, rd;
            logic        tk, ptk, jal, mp;
            pc   = $urandom() & 32'hFFFF_FFFC;
            tgt  = $urandom() & 32'hFFFF_FFFC;
            tk   = 1'($urandom_range(0, 1));
            jal  = tk & 1'($urandom_range(0, 1));
            ptk  = 1'($urandom_range(0, 1));
            ptgt = ($urandom_range(0, 1) == 1) ? tgt : ($urandom() & 32'hFFFF_FFFC);
            mp   = (tk != ptk) || (tk && (tgt != ptgt));
            rd   = tk ? tgt : pc + 32'd4;
            do_upd("rnd", pc, jal, tk, tgt, ptk, ptgt, mp, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
